// File: rtl/inst_fetch_stage.sv
`default_nettype none
// =============================================================================
// inst_fetch_stage : fetch PC, single-outstanding ROM handshake, decode queue.  Rev 1.0
// =============================================================================
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int c_ptr_w = $clog2(QDEPTH);
  localparam int c_cnt_w = $clog2(QDEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_pc;
  logic [31:0]          r_hold_addr;
  logic [31:0]          r_inst_q [QDEPTH];
  logic [31:0]          r_pc_q   [QDEPTH];
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_cnt_w-1:0]   w_count_nxt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;

  assign w_empty  = (r_count == '0);
  assign id_valid = !w_empty;
  assign id_inst  = w_empty ? 32'd0 : r_inst_q[r_rd_ptr];
  assign id_pc    = w_empty ? 32'd0 : r_pc_q[r_rd_ptr];

  // While discarding, the ROM still sees the abandoned address until it acks.
  assign rom_req  = (r_state != S_IDLE);
  assign rom_addr = (r_state == S_DISCARD) ? r_hold_addr : r_pc;

  assign w_push      = (r_state == S_REQ) && rom_ack && !redirect_valid;
  assign w_pop       = id_valid && id_ready && !redirect_valid;
  assign w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (redirect_valid || (r_count < c_full)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          w_state_nxt = rom_ack ? S_REQ : S_DISCARD;
        end else if (rom_ack && !(w_count_nxt < c_full)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (rom_ack) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_hold_addr <= RESET_PC;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_pc     <= redirect_pc & ~32'd3;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        if (r_state == S_REQ) r_hold_addr <= r_pc;
      end else begin
        r_count <= w_count_nxt;
        if (w_push) begin
          r_pc     <= r_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_q[r_wr_ptr] <= rom_rdata;
      r_pc_q[r_wr_ptr]   <= r_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_stage.sv
`default_nettype none
// =============================================================================
// tb_inst_fetch_stage : randomized phases against a queue-based fetch model.  Rev 1.0
// =============================================================================
module tb_inst_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam int          QDEPTH   = 2;
  localparam int          NPH      = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [31:0] rom_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  inst_fetch_stage #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_req        (rom_req),
    .rom_addr       (rom_addr),
    .rom_ack        (rom_ack),
    .rom_rdata      (rom_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: fetch queue of {pc, inst}, next fetch pc, and request flags.
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_req;
  bit          m_stale;

  int wait_cnt = 0;
  int lat      = 0;

  // Phase table: cycles, min/max ROM latency, ready %, redirect %, reset %.
  int ph_cyc  [NPH] = '{4, 20, 15, 15, 40, 60, 300, 300, 60};
  int ph_lmin [NPH] = '{0,  0,  0,  0,  2,  2,   0,   0,  0};
  int ph_lmax [NPH] = '{0,  0,  0,  0,  2,  2,   3,   1,  0};
  int ph_rdy  [NPH] = '{100, 100, 0, 100, 100, 60, 50, 70, 30};
  int ph_redir[NPH] = '{0,  0,  0,  0,  0, 15,  10,  20, 30};
  int ph_rst  [NPH] = '{100, 0, 0,  0,  0,  0,   2,   1,  5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit pop;
    if (rst) begin
      m_q.delete();
      m_pc    = RESET_PC;
      m_addr  = RESET_PC;
      m_req   = 1'b0;
      m_stale = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      if (m_req && !m_stale && !rom_ack) begin
        m_stale = 1'b1;
        m_addr  = m_pc;
      end else if (m_stale && rom_ack) begin
        m_stale = 1'b0;
      end
      m_req = 1'b1;
      m_pc  = redirect_pc & ~32'd3;
    end else begin
      pop = (m_q.size() != 0) && id_ready;
      if (!m_req) begin
        m_req = (m_q.size() < QDEPTH);
      end else if (m_stale) begin
        if (rom_ack) m_stale = 1'b0;
      end else if (rom_ack) begin
        if (pop) void'(m_q.pop_front());
        pop = 1'b0;
        m_q.push_back({m_pc, rom_rdata});
        m_pc  = m_pc + 32'd4;
        m_req = (m_q.size() < QDEPTH);
      end
      if (pop) void'(m_q.pop_front());
    end
  endtask

  initial begin
    for (int p = 0; p < NPH; p++) begin
      lat = $urandom_range(ph_lmax[p], ph_lmin[p]);
      for (int c = 0; c < ph_cyc[p]; c++) begin
        @(posedge clk);
        #1;
        model_step();

        check("rom_req",  {31'd0, rom_req},  {31'd0, m_req});
        check("rom_addr", rom_addr, m_stale ? m_addr : m_pc);
        check("id_valid", {31'd0, id_valid}, {31'd0, (m_q.size() != 0)});
        check("id_inst",  id_inst, (m_q.size() != 0) ? m_q[0][31:0]  : 32'd0);
        check("id_pc",    id_pc,   (m_q.size() != 0) ? m_q[0][63:32] : 32'd0);

        rst            = ($urandom_range(99) < ph_rst[p]);
        id_ready       = ($urandom_range(99) < ph_rdy[p]);
        redirect_valid = ($urandom_range(99) < ph_redir[p]);
        case ($urandom_range(3))
          0:       redirect_pc = 32'h80000013;
          1:       redirect_pc = 32'hfffffff9;
          default: redirect_pc = $urandom;
        endcase
        if (m_req) begin
          rom_ack = (wait_cnt >= lat);
          if (rom_ack) begin
            wait_cnt = 0;
            lat      = $urandom_range(ph_lmax[p], ph_lmin[p]);
          end else begin
            wait_cnt++;
          end
        end else begin
          rom_ack  = 1'b0;
          wait_cnt = 0;
        end
        rom_rdata = $urandom;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
Instruction-fetch stage of the MIPS core, directly upstream of decode and downstream of the instruction ROM port inside top. Owns the fetch PC, runs a one-outstanding request/ack handshake to the instruction ROM, and buffers returned words with their PC in a small queue. Decode pops entries via valid/ready. Branch/exception redirects flush the stage.

Parameters:
RESET_PC, 32'hbfc00000, fetch address after reset
QDEPTH, 2, instruction queue entries (power of two, >=2)

Ports:
clk  in  1  core clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-high
rom_req  out  1  fetch request to instruction ROM
rom_addr  out  32  fetch word address; low 2 bits always 0
rom_ack  in  1  ROM returns rom_rdata for current request this cycle
rom_rdata  in  32  instruction word, valid when rom_ack=1
redirect_valid  in  1  one-cycle redirect pulse from execute
redirect_pc  in  32  new fetch PC; bits[1:0] ignored, forced to 0
id_valid  out  1  queue head valid to decode
id_ready  in  1  decode accepts head this cycle
id_inst  out  32  queue head instruction
id_pc  out  32  queue head PC

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, state<=IDLE, queue empty. Outputs during/after reset: rom_req=0, rom_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0. id_inst/id_pc read 0 whenever queue empty.
- rom_addr = registered pc; stable while rom_req=1 until ack.
- States: IDLE (rom_req=0), REQ (rom_req=1), DISCARD (rom_req=1, address of abandoned fetch held).
- IDLE -> REQ when registered count < QDEPTH; first cycle after reset release goes IDLE->REQ, so rom_req rises 1 cycle after rst falls.
- REQ, rom_ack=1, no redirect: push {pc,rom_rdata}; pc<=pc+4 (32-bit wrap, no flag). Next state REQ if count after this cycle's push/pop < QDEPTH, else IDLE. Ack may arrive in the first REQ cycle; with ack every cycle and id_ready=1, throughput is 1 instr/cycle.
- No bypass: id_valid rises the cycle after the pushing ack.
- Pop when id_valid & id_ready. Push and pop in the same cycle are both performed; count unchanged.
- Redirect (highest priority): queue flushed (same-cycle pop and push discarded), pc<=redirect_pc&~3.
  - From IDLE -> REQ next cycle.
  - From REQ with rom_ack=1 that cycle -> ack data dropped, REQ next cycle at new pc.
  - From REQ without ack -> DISCARD.
  - In DISCARD: hold rom_req/old address until rom_ack; drop that data; then REQ at new pc. Further redirects in DISCARD only update pc.
- Never more than one outstanding request; never push into a full queue (issue gated by count).
- rst mid-fetch abandons the outstanding request; the ROM must treat rom_req=0 as cancel.

Test Plan:
- Reset release, ROM acks same cycle, id_ready=1 -> rom_addr BFC00000, BFC00004, BFC00008 on consecutive cycles; id_pc follows one cycle later; id_valid first high 2 cycles after rst falls.
- id_ready=0, ack always 1 -> exactly 2 entries pushed (PCs BFC00000/04), rom_req drops to 0 and stays 0; assert id_ready -> BFC00000 popped, fetch resumes at BFC00008.
- ROM latency 3 cycles -> rom_req and rom_addr held stable 3 cycles per fetch; throughput 1 instr per 3 cycles.
- Redirect to 80000013 while request outstanding (latency 3) -> queue empty next cycle, old ack data never reaches id_inst, next rom_addr=80000010.
- Redirect in same cycle as rom_ack and id_ready with full queue -> no pop visible, queue empty, next rom_addr=redirect target, pc+4 not applied.
- rst asserted with request outstanding and queue full -> next cycle rom_req=0, id_valid=0, rom_addr=BFC00000.
